// File: rtl/display_pkg.sv
// Shared constants for the countdown timer / display slice.
// State encoding, blank levels and count range.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic BLANK_ON  = 1'b1;
  localparam logic BLANK_OFF = 1'b0;

  localparam logic [3:0] MAX_COUNT = 4'd15;

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer: 2-flop sync plus registered rising-edge pulse.
// Ports: clk, rst_n, btn (async level) -> pulse (1 cycle, 3 edges latency).
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable 4-bit countdown timer feeding the 7-segment decoder.
// Ports: clk, rst_n, start_btn, clear_btn, load_val -> data, blank, done.
// Optional: COUNTDOWN_TIMER_BLINK_ON_DONE_EN blinks the display in DONE.
module countdown_timer
  import display_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       clear_btn,
  input  logic [3:0] load_val,
  output logic [3:0] data,
  output logic       blank,
  output logic       done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

`ifdef COUNTDOWN_TIMER_BLINK_ON_DONE_EN
  localparam logic [PW-1:0] P_HALF = PW'(DIV / 2 - 1);
  localparam logic DONE_BLANK = BLANK_ON;
`else
  localparam logic DONE_BLANK = BLANK_OFF;
`endif

  if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
    $error("DIV must be even and at least 2");
  end

  state_t        state;
  state_t        nstate;
  logic [3:0]    ncount;
  logic [PW-1:0] presc;
  logic [PW-1:0] npre;
  logic [PW-1:0] pre_inc;
  logic          nblank;
  logic          ndone;
  logic          tick;
  logic          start_p;
  logic          clear_p;

  btn_sync_edge u_start (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (start_btn),
    .pulse (start_p)
  );

  btn_sync_edge u_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (clear_btn),
    .pulse (clear_p)
  );

  assign tick    = (presc == P_LAST);
  assign pre_inc = tick ? '0 : presc + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      data  <= 4'd0;
      presc <= '0;
      blank <= BLANK_ON;
      done  <= 1'b0;
    end else begin
      state <= nstate;
      data  <= ncount;
      presc <= npre;
      blank <= nblank;
      done  <= ndone;
    end
  end

  always_comb begin
    nstate = state;
    ncount = data;
    npre   = presc;
    nblank = blank;
    ndone  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ncount = load_val;
        nblank = BLANK_OFF;
        npre   = '0;
        if (start_p) begin
          if (load_val != 4'd0) begin
            nstate = ST_RUN;
          end else begin
            nstate = ST_DONE;
            ndone  = 1'b1;
            nblank = DONE_BLANK;
          end
        end
      end
      ST_RUN: begin
        npre = pre_inc;
        // last tick: DONE beats a coincident pause
        if (tick && data <= 4'd1) begin
          ncount = 4'd0;
          nstate = ST_DONE;
          ndone  = 1'b1;
          npre   = '0;
          nblank = DONE_BLANK;
        end else begin
          if (tick) ncount = data - 4'd1;
          if (start_p) nstate = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_p) nstate = ST_RUN;
      end
      ST_DONE: begin
        ncount = 4'd0;
`ifdef COUNTDOWN_TIMER_BLINK_ON_DONE_EN
        npre = pre_inc;
        if (tick || presc == P_HALF) nblank = ~blank;
`else
        npre   = '0;
        nblank = BLANK_OFF;
`endif
      end
      default: nstate = ST_IDLE;
    endcase
    if (clear_p) begin
      nstate = ST_IDLE;
      npre   = '0;
      ndone  = 1'b0;
      ncount = load_val;
      nblank = BLANK_OFF;
    end
  end

endmodule
